ms_timer_arbiter: RTL
=====================

Name: ms_timer_arbiter

Overview:
- Shares one millisecond countdown timer among N_REQ requesters, e.g. coin-return timeout, dispense motor pulse and change-output delay.
- Contains its own prescaler that turns clk into 1 ms ticks.
- Grants the timer to one requester at a time by round-robin, counts down the requested number of ticks, then signals completion to the owner.
- Sits between the vending FSM's timing requests and the system clock.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk); minimum 2.
- N_REQ, 4, number of requesters.
- DUR_W, 12, width of the duration fields, in ms ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- dur  in  N_REQ*DUR_W  per-requester duration; slice i is dur[i*DUR_W +: DUR_W].
- abort  in  1  cancels the running job.
- grant  out  N_REQ  one-hot, one-cycle pulse when a job is accepted.
- done  out  N_REQ  one-hot, one-cycle pulse when the owner's countdown completes.
- busy  out  1  high while a job is in RUN.
- remaining  out  DUR_W  ticks left in the current job.
- tick_1ms  out  1  one-cycle prescaler pulse; only occurs in RUN.

Behaviour:
- Reset, asynchronous on rst low:
  - state=IDLE; grant=0, done=0, busy=0, remaining=0, tick_1ms=0.
  - Prescaler=0, owner=0, RR pointer set so ch0 has highest priority.
  - Reset applies mid-job; the job is discarded with no done.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, when any req bit is high at an edge:
  - Select the first requesting channel at or after (last owner + 1) mod N_REQ.
  - Latch owner and its dur slice into remaining; pulse grant[owner] for the following cycle; clear the prescaler.
  - If dur != 0: go to RUN with busy=1.
  - If dur == 0: go directly to DONE, with no ticks.
  - If no req is high: stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. tick_1ms pulses in the cycle after the prescaler reaches TICK_DIV-1.
  - On each wrap, remaining decrements.
  - On the wrap where remaining goes 1→0: go to DONE and set busy=0.
  - req and dur changes during RUN are ignored; dur is sampled only at grant.
- DONE: done[owner] is high for exactly one cycle. The RR pointer updates to owner. The next state is IDLE.
- Timing:
  - grant is high in cycle G.
  - done is high in cycle G + dur*TICK_DIV for dur ≥ 1, and in cycle G+1 for dur=0.
  - Minimum gap between successive grants is 2 cycles: DONE, then IDLE arbitration.
- abort:
  - Acts only in RUN. Next state is IDLE; remaining=0, busy=0, prescaler=0, no done.
  - The pointer still advances past the aborted owner.
  - abort in the same cycle as the final tick wins: no done.
  - abort in IDLE or DONE is ignored.
- Requesters must drop req on done, or they are re-granted when their turn comes round again.
- Arithmetic: remaining never underflows. The prescaler counter is ceil(log2(TICK_DIV)) bits.

Test Plan (TICK_DIV=10, N_REQ=4, DUR_W=12):
1. req[0]=1 with dur0=3 after reset, then drop req on grant:
   - grant[0] pulses 1 cycle after req is sampled.
   - remaining reads 3→2→1→0 at 10-cycle spacing; tick_1ms pulses 3 times.
   - done[0] fires exactly 30 cycles after grant; busy is low afterwards.
2. req[0] and req[2] asserted simultaneously, each held until its own done:
   - grant[0] comes first; grant[2] comes 2 cycles after done[0].
   - If req[0] is then reasserted, ch0 is granted next.
3. All four req held high continuously, dur=1:
   - Grant order is 0,1,2,3,0.
   - Each done falls 10 cycles after its grant.
4. dur1=0:
   - grant[1] is followed by done[1] on the next cycle.
   - busy never rises; tick_1ms never pulses.
5. dur3=5 with abort asserted at tick 2, and a separate run with abort coincident with the final tick:
   - No done in either case.
   - busy=0 and remaining=0 the cycle after abort.
   - The next pending requester is served normally.
6. rst pulsed low mid-RUN (remaining=4):
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, a ch2 request alone is granted, and the pointer priority is back to ch0.

Source files
------------

// File: rtl/ms_timer_arbiter.sv
// Purpose: round-robin owner of one shared 1 ms countdown timer, with a built-in clk-to-1ms prescaler.
// Latency: grant 1 cycle after req is sampled; done dur*TICK_DIV cycles after grant (dur=0: next cycle).
// Backpressure: none; requesters hold req until grant and must drop it by done or be re-granted in turn.
module ms_timer_arbiter #(
   parameter int TICK_DIV = 100000,
   parameter int N_REQ    = 4,
   parameter int DUR_W    = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*DUR_W-1:0] dur,
   input  logic                   abort,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [DUR_W-1:0]       remaining,
   output logic                   tick_1ms
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     presc, presc_nxt;
   logic [OW-1:0]     owner, owner_nxt;
   logic [OW-1:0]     last, last_nxt;
   logic [N_REQ-1:0]  grant_nxt, done_nxt;
   logic              busy_nxt, tick_nxt;
   logic [DUR_W-1:0]  rem_nxt;
   logic              pick_vld;
   logic [OW-1:0]     pick;
   logic              wrap;
   logic [DUR_W-1:0]  dur_a [N_REQ];

   // Unpack the flat duration bus into per-channel slices.
   for (genvar g = 0; g < N_REQ; g++) begin : g_dur
      assign dur_a[g] = dur[g*DUR_W +: DUR_W];
   end

   assign wrap = (presc == PRE_LAST);

   // Round-robin pick: first requester at or after last owner + 1, wrapping.
   always_comb begin
      int         idx;
      logic [OW-1:0] cand;
      idx      = 0;
      cand     = '0;
      pick_vld = 1'b0;
      pick     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = OW'(idx);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      owner_nxt = owner;
      last_nxt  = last;
      rem_nxt   = remaining;
      busy_nxt  = busy;
      grant_nxt = '0;
      done_nxt  = '0;
      tick_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               owner_nxt = pick;
               rem_nxt   = dur_a[pick];
               grant_nxt = ONE << pick;
               presc_nxt = '0;
               if (dur_a[pick] != '0) begin
                  state_nxt = RUN;
                  busy_nxt  = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         RUN: begin
            if (abort) begin
               // Abort beats a coincident final tick: no done, no tick.
               state_nxt = IDLE;
               rem_nxt   = '0;
               busy_nxt  = 1'b0;
               presc_nxt = '0;
               last_nxt  = owner;
            end else if (wrap) begin
               presc_nxt = '0;
               tick_nxt  = 1'b1;
               if (remaining != '0) rem_nxt = remaining - DUR_W'(1);
               if (remaining <= DUR_W'(1)) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = ONE << owner;
                  last_nxt  = owner;
               end
            end else begin
               presc_nxt = presc + PW'(1);
            end
         end
         DONE: begin
            // Countdown jobs arrive with done already pulsing; a zero-length
            // job spends one extra cycle here so done lands one after grant.
            if (done != '0) begin
               state_nxt = IDLE;
            end else begin
               done_nxt = ONE << owner;
               last_nxt = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc     <= '0;
         owner     <= '0;
         last      <= OW'(N_REQ - 1);
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         remaining <= '0;
         tick_1ms  <= 1'b0;
      end else begin
         presc     <= presc_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         grant     <= grant_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         remaining <= rem_nxt;
         tick_1ms  <= tick_nxt;
      end
   end

endmodule
